// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a word-addressed ROM from pc and buffers
// {pc, instruction} pairs in a small FIFO for the decode stage.
module fetch_unit #(
  parameter int           N         = 32,
  parameter int           INS       = 1000,
  parameter int           DEPTH     = 4,
  parameter logic [N-1:0] HALT_WORD = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] pc,
  input  logic [N-1:0] instruction,
  input  logic         start,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc,
  output logic         done
);

  localparam int           PW      = $clog2(DEPTH);
  localparam logic [N-1:0] INS_W   = N'(INS);
  localparam logic [N-1:0] LAST_PC = N'(INS - 1);
  localparam logic [PW:0]  FULL_CT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  pc_nxt;
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [N-1:0]  instr_mem [DEPTH];
  logic [N-1:0]  pc_mem    [DEPTH];
  logic          pop, push, full, flush;

  assign out_valid = (count != '0);
  assign out_instr = instr_mem[head];
  assign out_pc    = pc_mem[head];
  assign done      = (state == DONE) && (count == '0);

  always_comb begin
    full      = (count == FULL_CT);
    flush     = redirect && (state != IDLE);
    pop       = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    push      = (state == FETCH) && !flush && (!full || pop);
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (push) begin
          if ((instruction == HALT_WORD) || (pc == LAST_PC)) state_nxt = DONE;
          else                                               pc_nxt    = pc + 1'b1;
        end
      end
      default: ;
    endcase
    // An out-of-range target parks in DONE so the ROM is never read there.
    if (flush) begin
      pc_nxt    = redirect_pc;
      state_nxt = (redirect_pc >= INS_W) ? DONE : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop)  head <= head + 1'b1;
        if (push) tail <= tail + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= instruction;
      pc_mem[tail]    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural ROM and hand-computed
// expected fetch streams.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        start = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .start(start), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .done(done)
  );

  always #5 clk = ~clk;

  // Words 0..9 = 0x10..0x19, word 10 = halt, everything else is distinct data.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'd10)       return 32'h10 + a;
    else if (a == 32'd10) return 32'hFFFF_FFFF;
    else                  return 32'h1000 + a;
  endfunction

  assign instruction = rom(pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    start = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // With out_ready=1, every cycle showing out_valid is a pop; entries must
  // appear in address order. Returns with the entry 'last' still at the head.
  task automatic stream(input int first, input int last);
    int idx = first;
    int cyc = 0;
    while (idx <= last && cyc < 200) begin
      if (out_valid) begin
        chk("stream_pc", out_pc, 32'(idx));
        chk("stream_ins", out_instr, rom(32'(idx)));
        idx++;
      end
      if (idx <= last) step(1);
      cyc++;
    end
    if (idx <= last) chk("stream_timeout", 32'(idx), 32'(last + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    do_reset();

    // Redirect in IDLE has no effect
    redirect = 1'b1; redirect_pc = 32'd50;
    step(1);
    redirect = 1'b0;
    step(2);
    chk("idle_redir_pc", pc, 32'd0);
    chk("idle_redir_valid", {31'd0, out_valid}, 32'd0);

    // Full program run to the halt word
    out_ready = 1'b1;
    pulse_start();
    stream(0, 10);
    step(1);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_pc", pc, 32'd10);
    step(3);
    chk("halt_pc_hold", pc, 32'd10);

    // Back-pressure: queue fills and pc stalls
    do_reset();
    pulse_start();
    step(25);
    chk("full_pc", pc, 32'd4);
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_head_pc", out_pc, 32'd0);
    chk("full_head_ins", out_instr, 32'h10);
    // Single-cycle ready while full: one pop and one push together
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("swap_pc", pc, 32'd5);
    chk("swap_head_pc", out_pc, 32'd1);
    step(3);
    chk("swap_pc_hold", pc, 32'd5);
    chk("swap_head_hold", out_pc, 32'd1);
    out_ready = 1'b1;
    stream(1, 10);
    step(1);
    chk("bp_done", {31'd0, done}, 32'd1);

    // Redirect flushes three queued entries
    do_reset();
    pulse_start();
    step(3);
    chk("pre_redir_pc", pc, 32'd3);
    chk("pre_redir_head", out_pc, 32'd0);
    redirect = 1'b1; redirect_pc = 32'd100;
    step(1);
    redirect = 1'b0;
    chk("redir_pc", pc, 32'd100);
    chk("redir_flush", {31'd0, out_valid}, 32'd0);
    step(1);
    chk("redir_head_pc", out_pc, 32'd100);
    chk("redir_head_ins", out_instr, rom(32'd100));
    out_ready = 1'b1;
    stream(100, 103);

    // Last ROM word ends fetching without addressing past it
    redirect = 1'b1; redirect_pc = 32'd998;
    step(1);
    redirect = 1'b0;
    chk("end_redir_pc", pc, 32'd998);
    stream(998, 999);
    step(1);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_pc", pc, 32'd999);

    // Redirect beyond the ROM goes straight to DONE
    do_reset();
    pulse_start();
    step(3);
    redirect = 1'b1; redirect_pc = 32'd1000;
    step(1);
    redirect = 1'b0;
    chk("oob_done", {31'd0, done}, 32'd1);
    chk("oob_valid", {31'd0, out_valid}, 32'd0);
    chk("oob_pc", pc, 32'd1000);
    step(3);
    chk("oob_valid_hold", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream with two entries queued
    do_reset();
    pulse_start();
    step(2);
    chk("pre_arst_pc", pc, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pc", pc, 32'd0);
    #3;
    rst_n = 1'b1;
    step(5);
    chk("arst_no_fetch_pc", pc, 32'd0);
    chk("arst_no_fetch_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    pulse_start();
    stream(0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N: default 32; instruction and PC width in bits.
REQ-002 Parameter INS: default 1000; number of instruction words in the instruction ROM, word-indexed.
REQ-003 Parameter DEPTH: default 4; instruction queue entries, power of two, at least 2.
REQ-004 Parameter HALT_WORD: default all ones (N bits); instruction value that ends fetching.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pc  out  N  word address driven to instruction ROM.
REQ-008 instruction  in  N  ROM data for pc, valid combinationally in the same cycle.
REQ-009 start  in  1  one-cycle pulse; begins fetching from IDLE.
REQ-010 redirect  in  1  branch/jump request, sampled each cycle.
REQ-011 redirect_pc  in  N  new word address when redirect=1.
REQ-012 out_valid  out  1  queue head holds a valid instruction.
REQ-013 out_ready  in  1  consumer accepts head this cycle.
REQ-014 out_instr  out  N  instruction at queue head.
REQ-015 out_pc  out  N  word address of out_instr.
REQ-016 done  out  1  state DONE and queue empty.

Function
REQ-017 States: IDLE, FETCH, DONE, encoded in a state register.
REQ-018 IDLE->FETCH when start=1; start is ignored in FETCH and DONE.
REQ-019 Push: in FETCH, when queue not full or a pop occurs in the same cycle, {pc, instruction} is written at the tail and pc <= pc+1.
REQ-020 Pop: when out_valid=1 and out_ready=1, the head advances at the clock edge.
REQ-021 Simultaneous push and pop, including when full, leaves the count unchanged and both complete.
REQ-022 Pushing an instruction equal to HALT_WORD stores it, stops pc advancing (pc holds), and moves to DONE.
REQ-023 Pushing from pc=INS-1 moves to DONE; pc never addresses INS or higher.
REQ-024 Full queue with no pop: no push, pc holds, state holds.
REQ-025 redirect=1 in FETCH or DONE: queue flushed (count 0, same-cycle pop and push discarded), pc <= redirect_pc, state <= FETCH.
REQ-026 redirect_pc >= INS: queue flushed, pc <= redirect_pc, state <= DONE, no ROM read used.
REQ-027 redirect in IDLE is ignored.
REQ-028 out_valid = (count != 0); out_instr and out_pc come combinationally from the head entry.
REQ-029 Queue pointers wrap modulo DEPTH; count ranges from 0 to DEPTH.
REQ-030 Latency: instruction at address A reaches the head one edge after its push when the queue was empty.

Reset
REQ-031 While rst_n=0, regardless of clock: state=IDLE, pc=0, queue count=0, head/tail pointers=0, out_valid=0, done=0.
REQ-032 rst_n asserted mid-operation discards all queued instructions; after release, fetching resumes only on a new start.
REQ-033 out_instr and out_pc are don't-care while out_valid=0.

Verification
REQ-034 ROM words 0..9 = 0x10..0x19, word 10 = HALT_WORD; start with out_ready=1 -> out_pc 0..10 in order with out_instr 0x10..0x19 then HALT_WORD; done=1 one cycle after the last pop; pc holds 10.
REQ-035 out_ready=0 after start -> exactly DEPTH (4) pushes, pc=4, out_valid=1, out_pc=0; pc holds for 20 cycles; raising out_ready streams 0,1,2,... with no gaps or duplicates.
REQ-036 Queue full and out_ready=1 for one cycle -> one pop and one push on the same edge; count stays 4; pc goes 4->5.
REQ-037 redirect=1 with redirect_pc=100 while 3 entries are queued -> next cycle count=0 and pc=100; the following out_pc is 100; no stale entries from 0..3 appear.
REQ-038 redirect_pc=INS (1000) -> state DONE, done=1 next cycle, out_valid=0.
REQ-039 rst_n=0 asynchronously mid-stream with count=2 -> out_valid=0 and pc=0 immediately; after release, no fetch until start.
